nav_sched: RTL and testbench

- Schedules the shared navigation datapath (heading controller plus forward-move controller) between two requesters: the host command path and the autonomous maze solver.
- Buffers one command per requester and arbitrates between them, host first with an anti-starvation guard.
- Issues the start pulse, heading and stop-condition controls, waits for mv_cmplt with a watchdog, and returns a done or error pulse to the owning requester.

---
 rtl/nav_pkg.sv | 31 +++
 rtl/nav_sched_if.sv | 40 ++++
 rtl/nav_sched_req_slot.sv | 83 ++++++++
 rtl/nav_sched.sv | 219 +++++++++++++++++++++
 tb/tb_nav_sched.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nav_pkg.sv
// Shared types and constants for the navigation scheduler slice.
package nav_pkg;

  localparam int HDNG_W_DEF = 12;

  // Command opcodes as driven on host_op / slv_op.
  typedef enum logic [1:0] {
    OP_HDNG        = 2'b00,
    OP_MV          = 2'b01,
    OP_MV_STP_LFT  = 2'b10,
    OP_MV_STP_RGHT = 2'b11
  } nav_op_e;

  // Scheduler FSM encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_ISSUE      = 2'd1;
  localparam logic [1:0] ST_WAIT_CMPLT = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

  // Compass headings in the datapath's 12-bit signed encoding.
  localparam logic [11:0] HDNG_N = 12'h000;
  localparam logic [11:0] HDNG_W = 12'h3FF;
  localparam logic [11:0] HDNG_S = 12'h7FF;
  localparam logic [11:0] HDNG_E = 12'hC00;

  // Any opcode other than HDNG drives the forward-move controller.
  function automatic logic is_move(input nav_op_e op);
    return (op != OP_HDNG);
  endfunction

endpackage

// File: rtl/nav_sched_if.sv
// Bundle of requester, abort and datapath signals around the scheduler.
interface nav_if
  import nav_pkg::*;
#(
  parameter int HDNG_W = HDNG_W_DEF
);
  logic              host_req;
  logic [1:0]        host_op;
  logic [HDNG_W-1:0] host_hdng;
  logic              host_done;
  logic              host_err;
  logic              slv_req;
  logic [1:0]        slv_op;
  logic [HDNG_W-1:0] slv_hdng;
  logic              slv_done;
  logic              slv_err;
  logic              abort;
  logic              mv_cmplt;
  logic              strt_hdng;
  logic              strt_mv;
  logic [HDNG_W-1:0] dsrd_hdng;
  logic              stp_lft;
  logic              stp_rght;
  logic              busy;
  logic              owner;

  // Requesters and datapath side.
  modport master (
    output host_req, host_op, host_hdng, slv_req, slv_op, slv_hdng, abort, mv_cmplt,
    input  host_done, host_err, slv_done, slv_err, strt_hdng, strt_mv, dsrd_hdng,
           stp_lft, stp_rght, busy, owner
  );

  // Scheduler side.
  modport slave (
    input  host_req, host_op, host_hdng, slv_req, slv_op, slv_hdng, abort, mv_cmplt,
    output host_done, host_err, slv_done, slv_err, strt_hdng, strt_mv, dsrd_hdng,
           stp_lft, stp_rght, busy, owner
  );
endinterface

// File: rtl/nav_sched_req_slot.sv
// One-deep pending command buffer for a single requester, with overflow
// detection. An overflow that lands on the owner's done cycle is held back
// one cycle so done and err never coincide.
module nav_req_slot
  import nav_pkg::*;
#(
  parameter int HDNG_W = HDNG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [HDNG_W-1:0] hdng_i,
  input  logic              clr_i,
  input  logic              abort_i,
  input  logic              defer_i,
  output logic              valid_o,
  output nav_op_e           op_o,
  output logic [HDNG_W-1:0] hdng_o,
  output logic              ovf_o
);

  logic              valid_q, valid_d;
  nav_op_e           op_q, op_d;
  logic [HDNG_W-1:0] hdng_q, hdng_d;
  logic              pend_q, pend_d;
  logic              take_s;
  logic              ovf_evt_s;

  // Classify a request: accepted when the slot is free or freeing, else dropped.
  always_comb begin
    take_s    = 1'b0;
    ovf_evt_s = 1'b0;
    if (req_i && !abort_i) begin
      take_s    = !valid_q || clr_i;
      ovf_evt_s = valid_q && !clr_i;
    end else begin
      take_s    = 1'b0;
      ovf_evt_s = 1'b0;
    end
  end

  // Next slot contents: abort empties, new command overwrites, completion empties.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    hdng_d  = hdng_q;
    if (abort_i) begin
      valid_d = 1'b0;
    end else if (take_s) begin
      valid_d = 1'b1;
      op_d    = nav_op_e'(op_i);
      hdng_d  = hdng_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign ovf_o  = ovf_evt_s || pend_q;
  assign pend_d = ovf_o && defer_i;

  // Slot storage and deferred-overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= OP_HDNG;
      hdng_q  <= {HDNG_W{1'b0}};
      pend_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      hdng_q  <= hdng_d;
      pend_q  <= pend_d;
    end
  end

  assign valid_o = valid_q;
  assign op_o    = op_q;
  assign hdng_o  = hdng_q;

endmodule

// File: rtl/nav_sched.sv
// Navigation datapath scheduler: arbitrates host and maze-solver commands,
// issues start pulses, and supervises completion with a watchdog.
module nav_sched
  import nav_pkg::*;
#(
  parameter int TO_CYCLES       = 1_000_000,
  parameter int MAX_HOST_STREAK = 4,
  parameter int HDNG_W          = HDNG_W_DEF
) (
  input logic  clk,
  input logic  rst_n,
  nav_if.slave sched_io
);

  localparam int ST_W = (MAX_HOST_STREAK > 0) ? $clog2(MAX_HOST_STREAK + 1) : 1;
  localparam int WD_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [ST_W-1:0] STREAK_MAX = ST_W'(MAX_HOST_STREAK);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TO_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ST_W-1:0]   streak_q, streak_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [HDNG_W-1:0] dsrd_hdng_q, dsrd_hdng_d;
  logic              stp_lft_q, stp_lft_d;
  logic              stp_rght_q, stp_rght_d;
  logic              strt_hdng_q, strt_hdng_d;
  logic              strt_mv_q, strt_mv_d;
  logic              host_done_q, host_done_d;
  logic              slv_done_q, slv_done_d;
  logic              host_err_q, host_err_d;
  logic              slv_err_q, slv_err_d;
  logic              busy_q, busy_d;

  logic              host_vld_s, slv_vld_s;
  nav_op_e           host_op_s, slv_op_s, gnt_op_s;
  logic [HDNG_W-1:0] host_hdng_s, slv_hdng_s, gnt_hdng_s;
  logic              host_ovf_s, slv_ovf_s;
  logic              slv_win_s;
  logic              done_s, fsm_err_s, clr_own_s;
  logic              host_clr_s, slv_clr_s;

  assign host_clr_s = clr_own_s && !owner_q;
  assign slv_clr_s  = clr_own_s && owner_q;

  nav_req_slot #(.HDNG_W(HDNG_W)) u_host_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (sched_io.host_req),
    .op_i    (sched_io.host_op),
    .hdng_i  (sched_io.host_hdng),
    .clr_i   (host_clr_s),
    .abort_i (sched_io.abort),
    .defer_i (host_done_d),
    .valid_o (host_vld_s),
    .op_o    (host_op_s),
    .hdng_o  (host_hdng_s),
    .ovf_o   (host_ovf_s)
  );

  nav_req_slot #(.HDNG_W(HDNG_W)) u_slv_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (sched_io.slv_req),
    .op_i    (sched_io.slv_op),
    .hdng_i  (sched_io.slv_hdng),
    .clr_i   (slv_clr_s),
    .abort_i (sched_io.abort),
    .defer_i (slv_done_d),
    .valid_o (slv_vld_s),
    .op_o    (slv_op_s),
    .hdng_o  (slv_hdng_s),
    .ovf_o   (slv_ovf_s)
  );

  // Arbitration: solver wins when the host slot is empty or its streak is used up.
  always_comb begin
    if (slv_vld_s && (!host_vld_s || (streak_q == STREAK_MAX))) begin
      slv_win_s  = 1'b1;
      gnt_op_s   = slv_op_s;
      gnt_hdng_s = slv_hdng_s;
    end else begin
      slv_win_s  = 1'b0;
      gnt_op_s   = host_op_s;
      gnt_hdng_s = host_hdng_s;
    end
  end

  // Scheduler FSM next-state, grant loading, watchdog and abort override.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    wdog_d      = wdog_q;
    dsrd_hdng_d = dsrd_hdng_q;
    stp_lft_d   = stp_lft_q;
    stp_rght_d  = stp_rght_q;
    strt_hdng_d = 1'b0;
    strt_mv_d   = 1'b0;
    host_done_d = 1'b0;
    slv_done_d  = 1'b0;
    done_s      = 1'b0;
    fsm_err_s   = 1'b0;
    clr_own_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sched_io.abort && (host_vld_s || slv_vld_s)) begin
          state_d = ST_ISSUE;
          owner_d = slv_win_s;
          if (slv_win_s || !slv_vld_s) begin
            streak_d = {ST_W{1'b0}};
          end else begin
            streak_d = streak_q + ST_W'(1);
          end
          if (is_move(gnt_op_s)) begin
            strt_mv_d  = 1'b1;
            stp_lft_d  = (gnt_op_s == OP_MV_STP_LFT);
            stp_rght_d = (gnt_op_s == OP_MV_STP_RGHT);
          end else begin
            strt_hdng_d = 1'b1;
            dsrd_hdng_d = gnt_hdng_s;
            stp_lft_d   = 1'b0;
            stp_rght_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_CMPLT;
        wdog_d  = {WD_W{1'b0}};
      end
      ST_WAIT_CMPLT: begin
        if (sched_io.mv_cmplt) begin
          state_d = ST_DONE;
          done_s  = 1'b1;
        end else if (wdog_q == WD_LAST) begin
          state_d   = ST_IDLE;
          fsm_err_s = 1'b1;
          clr_own_s = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        clr_own_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (sched_io.abort) begin
      state_d     = ST_IDLE;
      streak_d    = {ST_W{1'b0}};
      strt_hdng_d = 1'b0;
      strt_mv_d   = 1'b0;
      fsm_err_s   = (state_q != ST_IDLE);
    end else begin
      host_done_d = done_s && !owner_q;
      slv_done_d  = done_s && owner_q;
    end
  end

  // Error pulses: FSM errors to the owner, overflow unless it collides with done.
  always_comb begin
    host_err_d = (fsm_err_s && !owner_q) || (host_ovf_s && !host_done_d);
    slv_err_d  = (fsm_err_s && owner_q) || (slv_ovf_s && !slv_done_d);
    busy_d     = (state_d != ST_IDLE);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      streak_q    <= {ST_W{1'b0}};
      wdog_q      <= {WD_W{1'b0}};
      dsrd_hdng_q <= {HDNG_W{1'b0}};
      stp_lft_q   <= 1'b0;
      stp_rght_q  <= 1'b0;
      strt_hdng_q <= 1'b0;
      strt_mv_q   <= 1'b0;
      host_done_q <= 1'b0;
      slv_done_q  <= 1'b0;
      host_err_q  <= 1'b0;
      slv_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      wdog_q      <= wdog_d;
      dsrd_hdng_q <= dsrd_hdng_d;
      stp_lft_q   <= stp_lft_d;
      stp_rght_q  <= stp_rght_d;
      strt_hdng_q <= strt_hdng_d;
      strt_mv_q   <= strt_mv_d;
      host_done_q <= host_done_d;
      slv_done_q  <= slv_done_d;
      host_err_q  <= host_err_d;
      slv_err_q   <= slv_err_d;
      busy_q      <= busy_d;
    end
  end

  assign sched_io.strt_hdng = strt_hdng_q;
  assign sched_io.strt_mv   = strt_mv_q;
  assign sched_io.dsrd_hdng = dsrd_hdng_q;
  assign sched_io.stp_lft   = stp_lft_q;
  assign sched_io.stp_rght  = stp_rght_q;
  assign sched_io.host_done = host_done_q;
  assign sched_io.slv_done  = slv_done_q;
  assign sched_io.host_err  = host_err_q;
  assign sched_io.slv_err   = slv_err_q;
  assign sched_io.busy      = busy_q;
  assign sched_io.owner     = owner_q;

endmodule

// File: tb/tb_nav_sched.sv
// Scoreboard bench for nav_sched: directed stimulus pushes expected output
// events with their cycle numbers; a negedge monitor pops and compares.
module tb_nav_sched;
  import nav_pkg::*;

  localparam int HW = 12;
  localparam int K_SH = 0;
  localparam int K_SM = 1;
  localparam int K_HD = 2;
  localparam int K_HE = 3;
  localparam int K_SD = 4;
  localparam int K_SE = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [HW-1:0] hdng;
    logic        lft;
    logic        rght;
  } exp_t;

  exp_t exp_q[$];
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   c0;

  nav_if #(.HDNG_W(HW)) bus ();

  nav_sched #(.TO_CYCLES(16), .MAX_HOST_STREAK(4), .HDNG_W(HW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sched_io (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic push(input int c, input int k, input logic [HW-1:0] h, input logic l, input logic r);
    exp_t e;
    e.cyc = c; e.kind = k; e.hdng = h; e.lft = l; e.rght = r;
    exp_q.push_back(e);
  endtask

  task automatic cmplt_at(input int c);
    wait_until(c);
    bus.mv_cmplt = 1'b1;
    tick(1);
    bus.mv_cmplt = 1'b0;
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    logic [5:0] ev;
    exp_t e;
    ev = {bus.slv_err, bus.slv_done, bus.host_err, bus.host_done, bus.strt_mv, bus.strt_hdng};
    if (rst_n) begin
      for (int k = 0; k < 6; k++) begin
        if (ev[k]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: actual kind %0d required none (cycle %0d)", k, cyc);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (k < 2) begin
              check("dsrd_hdng", {20'd0, bus.dsrd_hdng}, {20'd0, e.hdng});
              check("stp_lft", {31'd0, bus.stp_lft}, {31'd0, e.lft});
              check("stp_rght", {31'd0, bus.stp_rght}, {31'd0, e.rght});
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.host_req = 1'b0; bus.host_op = 2'b00; bus.host_hdng = 12'h000;
    bus.slv_req  = 1'b0; bus.slv_op  = 2'b00; bus.slv_hdng  = 12'h000;
    bus.abort    = 1'b0; bus.mv_cmplt = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state.
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_owner", {31'd0, bus.owner}, 32'd0);
    check("rst_dsrd_hdng", {20'd0, bus.dsrd_hdng}, 32'd0);
    check("rst_stp", {30'd0, bus.stp_lft, bus.stp_rght}, 32'd0);
    check("rst_pulses", {26'd0, bus.strt_hdng, bus.strt_mv, bus.host_done, bus.host_err,
                         bus.slv_done, bus.slv_err}, 32'd0);
    check("rst_slots", {30'd0, dut.u_host_slot.valid_q, dut.u_slv_slot.valid_q}, 32'd0);
    check("rst_streak", {29'd0, dut.streak_q}, 32'd0);

    // Host HDNG W, complete at +10.
    c0 = cyc;
    push(c0 + 2, K_SH, HDNG_W, 1'b0, 1'b0);
    push(c0 + 11, K_HD, 12'h000, 1'b0, 1'b0);
    bus.host_req = 1'b1; bus.host_op = OP_HDNG; bus.host_hdng = HDNG_W;
    tick(1);
    bus.host_req = 1'b0;
    cmplt_at(c0 + 10);
    check("s1_busy_in_done", {31'd0, bus.busy}, 32'd1);
    tick(1);
    check("s1_busy_after", {31'd0, bus.busy}, 32'd0);
    check("s1_hdng_hold", {20'd0, bus.dsrd_hdng}, {20'd0, HDNG_W});
    tick(2);

    // Simultaneous host MV_STP_LFT and solver MV: host first, solver after.
    c0 = cyc;
    push(c0 + 2, K_SM, HDNG_W, 1'b1, 1'b0);
    push(c0 + 6, K_HD, 12'h000, 1'b0, 1'b0);
    push(c0 + 8, K_SM, HDNG_W, 1'b0, 1'b0);
    push(c0 + 13, K_SD, 12'h000, 1'b0, 1'b0);
    bus.host_req = 1'b1; bus.host_op = OP_MV_STP_LFT;
    bus.slv_req = 1'b1; bus.slv_op = OP_MV;
    tick(1);
    bus.host_req = 1'b0; bus.slv_req = 1'b0;
    check("s2_owner_host", {31'd0, bus.owner}, 32'd0);
    cmplt_at(c0 + 5);
    wait_until(c0 + 8);
    check("s2_owner_slv", {31'd0, bus.owner}, 32'd1);
    cmplt_at(c0 + 12);
    tick(2);
    check("s2_streak", {29'd0, dut.streak_q}, 32'd0);

    // Host streak: four host grants, then solver HDNG S, then the last host.
    c0 = cyc;
    for (int g = 0; g < 4; g++) begin
      push(c0 + 2 + 4 * g, K_SM, HDNG_W, 1'b0, 1'b0);
      push(c0 + 4 + 4 * g, K_HD, 12'h000, 1'b0, 1'b0);
    end
    push(c0 + 18, K_SH, HDNG_S, 1'b0, 1'b0);
    push(c0 + 20, K_SD, 12'h000, 1'b0, 1'b0);
    push(c0 + 22, K_SM, HDNG_S, 1'b0, 1'b0);
    push(c0 + 24, K_HD, 12'h000, 1'b0, 1'b0);
    bus.host_op = OP_MV; bus.slv_op = OP_HDNG; bus.slv_hdng = HDNG_S;
    for (int i = 0; i <= 25; i++) begin
      bus.host_req = ((i % 4) == 0) && (i <= 16);
      bus.slv_req  = (i == 0);
      bus.mv_cmplt = ((i % 4) == 3);
      if (i == 14) check("s3_streak_max", {29'd0, dut.streak_q}, 32'd4);
      if (i == 18) check("s3_streak_cleared", {29'd0, dut.streak_q}, 32'd0);
      if (i == 18) check("s3_owner_slv", {31'd0, bus.owner}, 32'd1);
      tick(1);
    end
    bus.host_req = 1'b0; bus.slv_req = 1'b0; bus.mv_cmplt = 1'b0;
    tick(2);

    // Solver MV with no completion: watchdog error 16 cycles into WAIT_CMPLT.
    c0 = cyc;
    push(c0 + 2, K_SM, HDNG_S, 1'b0, 1'b0);
    push(c0 + 19, K_SE, 12'h000, 1'b0, 1'b0);
    bus.slv_req = 1'b1; bus.slv_op = OP_MV;
    tick(1);
    bus.slv_req = 1'b0;
    cmplt_at(c0 + 2);
    wait_until(c0 + 19);
    check("s4_busy_after_to", {31'd0, bus.busy}, 32'd0);
    check("s4_slot_empty", {31'd0, dut.u_slv_slot.valid_q}, 32'd0);
    tick(3);

    // Host overflow while in flight: err next cycle, original still completes.
    c0 = cyc;
    push(c0 + 2, K_SH, HDNG_E, 1'b0, 1'b0);
    push(c0 + 6, K_HE, 12'h000, 1'b0, 1'b0);
    push(c0 + 9, K_HD, 12'h000, 1'b0, 1'b0);
    bus.host_req = 1'b1; bus.host_op = OP_HDNG; bus.host_hdng = HDNG_E;
    tick(1);
    bus.host_req = 1'b0;
    wait_until(c0 + 5);
    bus.host_req = 1'b1; bus.host_hdng = HDNG_N;
    tick(1);
    bus.host_req = 1'b0;
    cmplt_at(c0 + 8);
    tick(1);
    check("s5_busy_after", {31'd0, bus.busy}, 32'd0);
    check("s5_hdng_hold", {20'd0, bus.dsrd_hdng}, {20'd0, HDNG_E});
    tick(3);

    // Abort in WAIT_CMPLT with solver pending, then abort with a req in IDLE.
    c0 = cyc;
    push(c0 + 2, K_SM, HDNG_E, 1'b0, 1'b1);
    push(c0 + 6, K_HE, 12'h000, 1'b0, 1'b0);
    bus.host_req = 1'b1; bus.host_op = OP_MV_STP_RGHT;
    tick(1);
    bus.host_req = 1'b0;
    wait_until(c0 + 3);
    bus.slv_req = 1'b1; bus.slv_op = OP_MV;
    tick(1);
    bus.slv_req = 1'b0;
    wait_until(c0 + 5);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check("s6_busy", {31'd0, bus.busy}, 32'd0);
    check("s6_slv_slot", {31'd0, dut.u_slv_slot.valid_q}, 32'd0);
    check("s6_streak", {29'd0, dut.streak_q}, 32'd0);
    wait_until(c0 + 8);
    bus.abort = 1'b1; bus.host_req = 1'b1; bus.host_op = OP_MV;
    tick(1);
    bus.abort = 1'b0; bus.host_req = 1'b0;
    tick(4);
    check("s6_host_slot", {31'd0, dut.u_host_slot.valid_q}, 32'd0);
    check("s6_idle", {31'd0, bus.busy}, 32'd0);

    // Overflow on the completion cycle: done first, err one cycle later.
    c0 = cyc;
    push(c0 + 2, K_SM, HDNG_E, 1'b0, 1'b0);
    push(c0 + 5, K_HD, 12'h000, 1'b0, 1'b0);
    push(c0 + 6, K_HE, 12'h000, 1'b0, 1'b0);
    bus.host_req = 1'b1; bus.host_op = OP_MV;
    tick(1);
    bus.host_req = 1'b0;
    wait_until(c0 + 4);
    bus.host_req = 1'b1; bus.mv_cmplt = 1'b1;
    tick(1);
    bus.host_req = 1'b0; bus.mv_cmplt = 1'b0;
    wait_until(c0 + 8);
    check("s7_busy", {31'd0, bus.busy}, 32'd0);
    check("s7_host_slot", {31'd0, dut.u_host_slot.valid_q}, 32'd0);

    tick(4);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
